// File: rtl/hdlverifier_capture_ctrl.sv
// Capture controller for the HDL Verifier data-capture path.
// Combines the comparators' trigger bits under a mask with an AND/OR rule. Runs a
// pre-/post-trigger window FSM that fills a circular capture RAM of 2^ADDR_WIDTH words.
module hdlverifier_capture_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NUM_TRIG   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [NUM_TRIG-1:0]   trigger_in,
    input  logic [NUM_TRIG-1:0]   trigger_enable_mask,
    input  logic                  trigger_combine,
    input  logic [ADDR_WIDTH-1:0] trigger_position,
    input  logic                  immediate_trigger,
    input  logic                  arm,
    input  logic                  abort,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  capture_done,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPrefill  = 3'd1,
        StWaitTrig = 3'd2,
        StPost     = 3'd3,
        StDone     = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_pre_cnt;
    logic [ADDR_WIDTH-1:0] r_post_cnt;
    logic [ADDR_WIDTH-1:0] r_pos;
    logic [ADDR_WIDTH-1:0] r_trig_addr;
    logic [ADDR_WIDTH-1:0] r_start_addr;
    logic [DATA_WIDTH-1:0] r_data_dly;

    logic                  w_busy;
    logic                  w_write;
    logic                  w_cond;
    logic                  w_arm_go;
    logic [ADDR_WIDTH-1:0] w_pre_inc;
    logic [ADDR_WIDTH-1:0] w_post_init;

    // Trigger condition and shared datapath terms. An all-zero mask never triggers, even in
    // AND mode where the reduction would otherwise be vacuously true.
    always_comb begin
        w_cond = 1'b0;
        if (|trigger_enable_mask) begin
            w_cond = trigger_combine ? |(trigger_in & trigger_enable_mask)
                                     : &(trigger_in | ~trigger_enable_mask);
        end
        w_cond      = w_cond | immediate_trigger;
        w_busy      = (r_state == StPrefill) || (r_state == StWaitTrig) || (r_state == StPost);
        w_write     = clk_enable & w_busy;
        w_arm_go    = arm & ~abort & ((r_state == StIdle) || (r_state == StDone));
        w_pre_inc   = r_pre_cnt + AddrOne;
        // D-1-pos; trigger_position cannot exceed D-1 at this width, so no clamp is needed.
        w_post_init = '1 - r_pos;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort overrides everything, including a simultaneous arm.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (arm) begin
                        w_state_next = (trigger_position == '0) ? StWaitTrig : StPrefill;
                    end
                end
                StPrefill: begin
                    if (clk_enable && (w_pre_inc == r_pos)) w_state_next = StWaitTrig;
                end
                StWaitTrig: begin
                    if (clk_enable && w_cond) begin
                        w_state_next = (w_post_init == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (clk_enable && (r_post_cnt == AddrOne)) w_state_next = StDone;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Sample delay, write address, window counters and trigger/start address capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_dly   <= '0;
            r_wr_addr    <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_pos        <= '0;
            r_trig_addr  <= '0;
            r_start_addr <= '0;
        end else begin
            // Keeps wr_data aligned with the registered comparator bits.
            if (clk_enable) r_data_dly <= data_in;
            if (w_arm_go) begin
                r_wr_addr <= '0;
                r_pre_cnt <= '0;
                r_pos     <= trigger_position;
            end else if (!abort && w_write) begin
                r_wr_addr <= r_wr_addr + AddrOne;
                if (r_state == StPrefill) r_pre_cnt <= w_pre_inc;
                if (r_state == StPost) r_post_cnt <= r_post_cnt - AddrOne;
                if ((r_state == StWaitTrig) && w_cond) begin
                    r_trig_addr  <= r_wr_addr;
                    r_start_addr <= r_wr_addr - r_pos;
                    r_post_cnt   <= w_post_init;
                end
            end
        end
    end

    // Outputs decoded from registered state, counters and delayed data.
    always_comb begin
        wr_en        = w_write;
        wr_addr      = r_wr_addr;
        wr_data      = r_data_dly;
        trigger_addr = r_trig_addr;
        start_addr   = r_start_addr;
        busy         = w_busy;
        capture_done = (r_state == StDone);
        state        = r_state;
    end

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Directed bench for hdlverifier_capture_ctrl with D=16 and a write scoreboard plus RAM model.
module tb_hdlverifier_capture_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NT = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_enable;
    logic [DW-1:0] data_in;
    logic [NT-1:0] trigger_in;
    logic [NT-1:0] trigger_enable_mask;
    logic          trigger_combine;
    logic [AW-1:0] trigger_position;
    logic          immediate_trigger;
    logic          arm;
    logic          abort;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trigger_addr;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          capture_done;
    logic [2:0]    state;

    hdlverifier_capture_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_TRIG  (NT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clk_enable         (clk_enable),
        .data_in            (data_in),
        .trigger_in         (trigger_in),
        .trigger_enable_mask(trigger_enable_mask),
        .trigger_combine    (trigger_combine),
        .trigger_position   (trigger_position),
        .immediate_trigger  (immediate_trigger),
        .arm                (arm),
        .abort              (abort),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .trigger_addr       (trigger_addr),
        .start_addr         (start_addr),
        .busy               (busy),
        .capture_done       (capture_done),
        .state              (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mem[D];
    logic [DW-1:0] m_dly;
    logic [DW-1:0] next_d;
    logic [DW-1:0] first_d;
    int            exp_addr;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every DUT write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            mem[wr_addr] = wr_data;
            checks++;
            assert (exp_q.size() > 0)
            else begin
                errors++;
                $error("FAIL unexpected_write: observed write at addr %0d, expected none", wr_addr);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", DW'(wr_addr), DW'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    // One clock: drive inputs, predict the write if any, advance the data_dly model.
    task automatic tick(input logic ce, input logic [NT-1:0] trig, input bit exp_wr);
        wr_t e;
        clk_enable = ce;
        trigger_in = trig;
        data_in    = next_d;
        if (ce && exp_wr) begin
            e.addr = exp_addr[AW-1:0];
            e.data = m_dly;
            exp_q.push_back(e);
            exp_addr = (exp_addr + 1) % D;
        end
        @(posedge clk);
        #1;
        if (ce) begin
            m_dly  = next_d;
            next_d = next_d + 1;
        end
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] pos);
        trigger_position = pos;
        arm = 1'b1;
        tick(1'b0, '0, 1'b0);
        exp_addr = 0;
    endtask

    task automatic chk_st(input string tag, input int st, input logic b, input logic dn);
        chk({tag, "_state"}, DW'(state), DW'(st));
        chk({tag, "_busy"}, DW'(busy), DW'(b));
        chk({tag, "_done"}, DW'(capture_done), DW'(dn));
    endtask

    task automatic chk_addrs(input string tag, input int ta, input int sa);
        chk({tag, "_trigger_addr"}, DW'(trigger_addr), DW'(ta));
        chk({tag, "_start_addr"}, DW'(start_addr), DW'(sa));
    endtask

    task automatic chk_ram(input string tag, input int sa, input logic [DW-1:0] first);
        for (int i = 0; i < D; i++) chk(tag, mem[(sa + i) % D], first + DW'(i));
    endtask

    initial begin
        rst_n = 1'b0; clk_enable = 1'b0; data_in = '0; trigger_in = '0;
        trigger_enable_mask = '0; trigger_combine = 1'b0; trigger_position = '0;
        immediate_trigger = 1'b0; arm = 1'b0; abort = 1'b0;
        next_d = 1; m_dly = 0; exp_addr = 0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        #12;
        chk_st("rst", 0, 1'b0, 1'b0);
        chk("rst_wr_en", DW'(wr_en), 0);
        chk("rst_wr_addr", DW'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk_addrs("rst", 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A: OR mode, mask 0001, pos 4, trigger on sample 20; buffer wraps twice.
        trigger_combine = 1'b1; trigger_enable_mask = 4'b0001;
        do_arm(4);
        chk_st("a_arm", 1, 1'b1, 1'b0);
        trigger_position = 9;  // must be ignored while busy
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0001, 1'b1);
        chk_st("a_prefill", 2, 1'b1, 1'b0);
        for (int i = 4; i < 20; i++) begin
            if (i == 10) arm = 1'b1;
            tick(1'b1, 4'b1110, 1'b1);
        end
        chk_st("a_wait", 2, 1'b1, 1'b0);
        chk("a_dly20", m_dly, 20);
        tick(1'b1, 4'b0001, 1'b1);
        chk_st("a_trig", 3, 1'b1, 1'b0);
        chk_addrs("a", 4, 0);
        for (int i = 0; i < 11; i++) tick(1'b1, 4'b0000, 1'b1);
        chk_st("a_done", 4, 1'b0, 1'b1);
        tick(1'b1, 4'b0001, 1'b0);
        tick(1'b1, 4'b0001, 1'b0);
        chk("a_queue", DW'(exp_q.size()), 0);
        chk_ram("a_ram", 0, 16);

        // B: AND mode, mask 0101; re-arm from DONE restarts at address 0.
        trigger_combine = 1'b0; trigger_enable_mask = 4'b0101;
        do_arm(4);
        chk_st("b_arm", 1, 1'b1, 1'b0);
        chk("b_wr_addr", DW'(wr_addr), 0);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0101, 1'b1);
        tick(1'b1, 4'b0001, 1'b1);
        tick(1'b1, 4'b0100, 1'b1);
        tick(1'b1, 4'b1011, 1'b1);
        chk_st("b_wait", 2, 1'b1, 1'b0);
        tick(1'b1, 4'b0101, 1'b1);
        chk_st("b_trig", 3, 1'b1, 1'b0);
        chk_addrs("b", 7, 3);
        for (int i = 0; i < 11; i++) tick(1'b1, 4'b0000, 1'b1);
        chk_st("b_done", 4, 1'b0, 1'b1);
        chk("b_queue", DW'(exp_q.size()), 0);

        // C: mask 0000 never triggers in either mode; abort returns to IDLE.
        trigger_enable_mask = 4'b0000;
        do_arm(4);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) begin
            trigger_combine = i[0];
            tick(1'b1, 4'b1111, 1'b1);
        end
        chk_st("c_wait", 2, 1'b1, 1'b0);
        abort = 1'b1;
        tick(1'b0, 4'b1111, 1'b0);
        chk_st("c_abort", 0, 1'b0, 1'b0);
        chk_addrs("c_abort", 7, 3);
        chk("c_queue", DW'(exp_q.size()), 0);

        // C2: immediate_trigger ignored in PREFILL, fires on first WAIT_TRIG enabled cycle.
        immediate_trigger = 1'b1;
        do_arm(2);
        for (int i = 0; i < 2; i++) tick(1'b1, 4'b0000, 1'b1);
        chk_st("imm_prefill", 2, 1'b1, 1'b0);
        tick(1'b1, 4'b0000, 1'b1);
        immediate_trigger = 1'b0;
        chk_st("imm_trig", 3, 1'b1, 1'b0);
        chk_addrs("imm", 2, 0);
        for (int i = 0; i < 13; i++) tick(1'b1, 4'b0000, 1'b1);
        chk_st("imm_done", 4, 1'b0, 1'b1);

        // D: pos 0 skips PREFILL (15 post writes); pos 15 has no post writes.
        trigger_combine = 1'b1; trigger_enable_mask = 4'b0001;
        do_arm(0);
        chk_st("p0_arm", 2, 1'b1, 1'b0);
        tick(1'b1, 4'b0001, 1'b1);
        chk_addrs("p0", 0, 0);
        for (int i = 0; i < 14; i++) tick(1'b1, 4'b0000, 1'b1);
        chk_st("p0_post14", 3, 1'b1, 1'b0);
        tick(1'b1, 4'b0000, 1'b1);
        chk_st("p0_done", 4, 1'b0, 1'b1);
        do_arm(15);
        chk_st("p15_arm", 1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b1, 4'b0001, 1'b1);
        chk_st("p15_prefill", 2, 1'b1, 1'b0);
        tick(1'b1, 4'b0001, 1'b1);
        chk_st("p15_done", 4, 1'b0, 1'b1);
        chk_addrs("p15", 15, 0);
        tick(1'b1, 4'b0001, 1'b0);
        chk("p15_queue", DW'(exp_q.size()), 0);

        // E: clk_enable toggling, trigger held through PREFILL.
        do_arm(4);
        first_d = m_dly;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'b0001, 1'b1);
            tick(1'b0, 4'b0001, 1'b0);
        end
        chk_st("e_prefill", 2, 1'b1, 1'b0);
        tick(1'b1, 4'b0001, 1'b1);
        chk_st("e_trig", 3, 1'b1, 1'b0);
        chk_addrs("e", 4, 0);
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, 4'b0000, 1'b0);
            tick(1'b1, 4'b0000, 1'b1);
        end
        chk_st("e_done", 4, 1'b0, 1'b1);
        chk("e_queue", DW'(exp_q.size()), 0);
        chk_ram("e_ram", 0, first_d);

        // G: abort and arm together in POST.
        do_arm(4);
        for (int i = 0; i < 4; i++) tick(1'b1, 4'b0000, 1'b1);
        tick(1'b1, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b0000, 1'b1);
        abort = 1'b1; arm = 1'b1;
        tick(1'b0, 4'b0000, 1'b0);
        chk_st("g_abort", 0, 1'b0, 1'b0);
        chk_addrs("g_abort", 4, 0);
        tick(1'b1, 4'b0000, 1'b0);
        chk("g_queue", DW'(exp_q.size()), 0);

        // H: asynchronous reset in POST clears everything without a clock edge.
        trigger_enable_mask = 4'b0011;
        do_arm(3);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'b0000, 1'b1);
        tick(1'b1, 4'b0010, 1'b1);
        tick(1'b1, 4'b0000, 1'b1);
        tick(1'b1, 4'b0000, 1'b1);
        chk_st("h_post", 3, 1'b1, 1'b0);
        clk_enable = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk_st("h_rst", 0, 1'b0, 1'b0);
        chk("h_wr_en", DW'(wr_en), 0);
        chk("h_wr_addr", DW'(wr_addr), 0);
        chk("h_wr_data", wr_data, 0);
        chk_addrs("h_rst", 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_dly = 0;
        tick(1'b1, 4'b0000, 1'b0);
        chk("h_queue", DW'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdlverifier_capture_ctrl.md
Name: hdlverifier_capture_ctrl

Overview:
Capture controller that sits directly downstream of the per-signal trigger comparators in the HDL Verifier data-capture path. It combines the comparators' registered trigger bits under an enable mask and an AND/OR rule, and runs a pre-/post-trigger window state machine. It drives write address, data and enable into a circular capture RAM of 2^ADDR_WIDTH words. It reports the trigger address, the readout start address and a done flag to the host-side readout logic.

Parameters:
DATA_WIDTH, 32, width of captured sample word
ADDR_WIDTH, 10, capture RAM address width; depth D = 2^ADDR_WIDTH
NUM_TRIG, 4, number of comparator trigger inputs

Ports:
clk  input  1  capture clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
clk_enable  input  1  sample qualifier; same signal that feeds the comparators
data_in  input  DATA_WIDTH  sample word, same cycle as comparator data input
trigger_in  input  NUM_TRIG  registered comparator outputs (one enabled-cycle latency vs data_in)
trigger_enable_mask  input  NUM_TRIG  1 = bit participates in the trigger condition
trigger_combine  input  1  0 = AND of enabled bits, 1 = OR of enabled bits
trigger_position  input  ADDR_WIDTH  number of pre-trigger samples, sampled on arm
immediate_trigger  input  1  force trigger condition true, WAIT_TRIG only
arm  input  1  start capture, single-cycle pulse
abort  input  1  cancel capture
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_WIDTH  RAM write address
wr_data  output  DATA_WIDTH  RAM write data
trigger_addr  output  ADDR_WIDTH  RAM address of the trigger sample
start_addr  output  ADDR_WIDTH  oldest sample address = trigger_addr - pos, mod D
busy  output  1  high in PREFILL, WAIT_TRIG and POST
capture_done  output  1  high in DONE
state  output  3  IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, DONE=4

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0, data_dly 0.
- Alignment: data_dly <= data_in on every clk_enable cycle, in all states. trigger_in in a given enabled cycle describes data_dly. wr_data = data_dly.
- Trigger condition cond:
  - AND mode: &(trigger_in | ~mask).
  - OR mode: |(trigger_in & mask).
  - mask == 0 gives cond = 0 in both modes.
  - cond is OR-ed with immediate_trigger.
- pos = min(trigger_position, D-1), latched on arm. post_cnt = D-1-pos.
- Write rule: in PREFILL, WAIT_TRIG and POST, every clk_enable cycle asserts wr_en for exactly that cycle.
  - Write occurs at the current wr_addr, after which wr_addr increments mod D.
  - wr_en is always 0 when clk_enable = 0 or outside these states.
  - wr_en, wr_addr and wr_data are combinational from the registered state, counter and data_dly.
- IDLE / DONE -> PREFILL on arm: wr_addr <= 0, pre counter <= 0, capture_done <= 0. If pos == 0, go straight to WAIT_TRIG.
- PREFILL: triggers are ignored. Each write increments the pre counter. On the write that brings the counter to pos, move to WAIT_TRIG next cycle.
- WAIT_TRIG: writes continue and wrap around the buffer.
  - On an enabled cycle with cond = 1, that cycle's sample is the trigger sample: trigger_addr <= wr_addr, start_addr <= wr_addr - pos (mod D).
  - If post_cnt == 0, go to DONE. Otherwise load the post counter and go to POST.
- POST: each write decrements the post counter. On the write that reaches 0, go to DONE.
  - Total samples after the trigger = D-1-pos.
  - The buffer holds exactly D contiguous samples.
- DONE: capture_done = 1, busy = 0, no writes. trigger_addr and start_addr are held until the next arm.
- arm while busy is ignored. Changes to trigger_position while busy are ignored.
- abort in any state sends the FSM to IDLE next cycle and clears busy and capture_done. trigger_addr and start_addr are unchanged. abort wins over a simultaneous arm.
- Asynchronous reset mid-capture returns everything to reset values immediately. No partial state is retained.
- trigger_in is don't-care outside WAIT_TRIG.

Test Plan:
- ADDR_WIDTH=4 (D=16), pos=4, OR, mask=0001; data_in ramps 1,2,3...; trigger_in[0] is high for the sample with data_dly = 20 -> wr_en on every enabled cycle; the trigger sample is written at trigger_addr; exactly 11 more writes follow, then capture_done=1; start_addr = trigger_addr-4 mod 16; RAM holds 16 consecutive values with 20 at index 4 from start_addr.
- AND mode, mask=0101: first trigger_in=0001, later 0101 -> no trigger on 0001, trigger on the 0101 cycle; mask=0000 -> never triggers; immediate_trigger -> triggers on the first WAIT_TRIG enabled cycle.
- trigger_position=0 and trigger_position=15 -> pos=0: PREFILL skipped, 15 post writes; pos=15: zero post writes, DONE on the cycle after the trigger write.
- clk_enable toggling 1,0,1,0 during PREFILL and POST -> wr_en only on enabled cycles; counts and total number of writes unchanged (16).
- Trigger held high during PREFILL with pos=4 -> ignored; trigger fires on the first WAIT_TRIG enabled cycle; trigger_addr=4.
- abort and arm together in POST -> IDLE, busy=0, capture_done=0; separately, rst_n low in POST -> all outputs 0 at once; arm issued in DONE -> new capture restarts at wr_addr 0.
